// File: rtl/sgpr_ram.sv
// Purpose : banked SGPR storage with RD_PORT_CNT read operands per request, one write port and post-reset zero-init.
// Latency : response valid RD_LAT cycles after the accepting edge; writes commit at their edge; req_err one cycle after the offending edge.
// Backpr. : none; requests and writes arriving during init are dropped and flagged on req_err.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   rd_req_valid, rd_req_addr      read request, port i address at [i*ADDR_W +: ADDR_W]
//   rd_resp_valid, rd_resp_data    read response, port i operand at [i*DATA_W +: DATA_W]; data holds when not valid
//   wr_req_valid/addr/data         write strobe, address and data
//   init_busy                      high while the array is being zeroed
//   req_err                        pulse: request dropped during init, or an address >= DEPTH
//
// Build option SGPR_RAM_WR_BYPASS_EN: when defined, a read port that hits the address of a
// write committed in the same cycle returns the new write data; otherwise it returns the old value.

module sgpr_ram #(
   parameter int RD_PORT_CNT = 3,
   parameter int DEPTH       = 128,
   parameter int DATA_W      = 32,
   parameter int RD_LAT      = 2,
   localparam int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rd_req_valid,
   input  logic [RD_PORT_CNT*ADDR_W-1:0] rd_req_addr,
   output logic                          rd_resp_valid,
   output logic [RD_PORT_CNT*DATA_W-1:0] rd_resp_data,
   input  logic                          wr_req_valid,
   input  logic [ADDR_W-1:0]             wr_req_addr,
   input  logic [DATA_W-1:0]             wr_req_data,
   output logic                          init_busy,
   output logic                          req_err
);

`ifdef SGPR_RAM_WR_BYPASS_EN
   localparam bit WR_BYPASS = 1'b1;
`else
   localparam bit WR_BYPASS = 1'b0;
`endif

   // One extra bit so the range check stays meaningful when DEPTH is a power of two.
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                     ready;
   logic                     rd_acc;
   logic                     wr_in_range;
   logic                     wr_commit;
   logic                     err_d;
   logic [RD_PORT_CNT-1:0]   rd_oor;
   logic [RD_PORT_CNT*DATA_W-1:0] rd_word;

   logic [RD_LAT-1:0]               vld_q;
   logic [RD_PORT_CNT*DATA_W-1:0]   dat_q [RD_LAT];

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_X;
   endfunction

   // Init sequencer: one entry per cycle, READY is terminal until the next reset.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end
         end
         ST_READY: begin
            state_d = ST_READY;
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   assign ready       = (state_q == ST_READY);
   assign init_busy   = (state_q == ST_INIT);
   assign rd_acc      = rd_req_valid && ready;
   assign wr_in_range = in_range(wr_req_addr);
   assign wr_commit   = wr_req_valid && ready && wr_in_range;

   // Array read at the accepting edge; out-of-range ports return zero.
   always_comb begin
      rd_word = '0;
      rd_oor  = '0;
      for (int p = 0; p < RD_PORT_CNT; p++) begin
         if (!in_range(rd_req_addr[p*ADDR_W +: ADDR_W])) begin
            rd_oor[p] = 1'b1;
         end else if (WR_BYPASS && wr_commit &&
                      (wr_req_addr == rd_req_addr[p*ADDR_W +: ADDR_W])) begin
            rd_word[p*DATA_W +: DATA_W] = wr_req_data;
         end else begin
            rd_word[p*DATA_W +: DATA_W] = mem[rd_req_addr[p*ADDR_W +: ADDR_W]];
         end
      end
   end

   assign err_d = (init_busy && (rd_req_valid || wr_req_valid))
                | (rd_acc && (|rd_oor))
                | (wr_req_valid && ready && !wr_in_range);

   // Storage has no reset; contents are owned by the init sequencer.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem[cnt_q] <= '0;
      end else if (wr_commit) begin
         mem[wr_req_addr] <= wr_req_data;
      end
   end

   // Control state and the response pipeline. Data stages only load behind a valid,
   // so the output data holds its last value between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         req_err <= 1'b0;
         vld_q   <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            dat_q[s] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_err  <= err_d;
         vld_q[0] <= rd_acc;
         if (rd_acc) begin
            dat_q[0] <= rd_word;
         end
         for (int s = 1; s < RD_LAT; s++) begin
            vld_q[s] <= vld_q[s-1];
            if (vld_q[s-1]) begin
               dat_q[s] <= dat_q[s-1];
            end
         end
      end
   end

   assign rd_resp_valid = vld_q[RD_LAT-1];
   assign rd_resp_data  = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_sgpr_ram.sv
// Bench for sgpr_ram: two instances (DEPTH 128 and DEPTH 106) share all inputs.
// Outputs are sampled on the falling edge; inputs change on the falling edge.

module tb_sgpr_ram;

   localparam int NP  = 3;
   localparam int DW  = 32;
   localparam int AW  = 7;
   localparam int LAT = 2;

`ifdef SGPR_RAM_WR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rd_req_valid = 1'b0;
   logic [NP*AW-1:0]  rd_req_addr = '0;
   logic              wr_req_valid = 1'b0;
   logic [AW-1:0]     wr_req_addr = '0;
   logic [DW-1:0]     wr_req_data = '0;

   logic              vld0, vld1, busy0, busy1, err0, err1;
   logic [NP*DW-1:0]  dat0, dat1;

   always #5 clk = ~clk;

   sgpr_ram #(.RD_PORT_CNT(NP), .DEPTH(128), .DATA_W(DW), .RD_LAT(LAT)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
      .rd_resp_valid(vld0), .rd_resp_data(dat0),
      .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
      .init_busy(busy0), .req_err(err0)
   );

   sgpr_ram #(.RD_PORT_CNT(NP), .DEPTH(106), .DATA_W(DW), .RD_LAT(LAT)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
      .rd_resp_valid(vld1), .rd_resp_data(dat1),
      .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
      .init_busy(busy1), .req_err(err1)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Per instance: edges seen since reset release, a flat storage image, and the
   // response each accepted request must produce, keyed by the edge after which it shows.
   int                m_k   [2];
   logic              m_vld [2];
   logic              m_err [2];
   logic [95:0]       m_dat [2];
   logic [31:0]       m_mem [2][128];
   logic [95:0]       resp_at [int];

   function automatic int dep(input int d);
      return (d == 0) ? 128 : 106;
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         m_k[d] = 0; m_vld[d] = 1'b0; m_err[d] = 1'b0; m_dat[d] = '0;
      end
      resp_at.delete();
   endfunction

   function automatic void model_edge(input int d);
      int          k;
      int          a;
      logic        e;
      logic [95:0] r;
      k = m_k[d] + 1;
      e = 1'b0;
      r = '0;
      if (m_k[d] >= dep(d)) begin
         if (rd_req_valid) begin
            for (int p = 0; p < NP; p++) begin
               a = int'(rd_req_addr[p*AW +: AW]);
               if (a >= dep(d)) e = 1'b1;
               else if (BYP && wr_req_valid && int'(wr_req_addr) == a) r[p*DW +: DW] = wr_req_data;
               else r[p*DW +: DW] = m_mem[d][a];
            end
            resp_at[(k + LAT - 1) * 2 + d] = r;
         end
         if (wr_req_valid) begin
            if (int'(wr_req_addr) >= dep(d)) e = 1'b1;
            else m_mem[d][wr_req_addr] = wr_req_data;
         end
      end else begin
         if (rd_req_valid || wr_req_valid) e = 1'b1;
         if (k == dep(d)) begin
            for (int i = 0; i < 128; i++) m_mem[d][i] = '0;
         end
      end
      m_k[d]   = k;
      m_err[d] = e;
      if (resp_at.exists(k * 2 + d)) begin
         m_vld[d] = 1'b1;
         m_dat[d] = resp_at[k * 2 + d];
         resp_at.delete(k * 2 + d);
      end else begin
         m_vld[d] = 1'b0;
      end
   endfunction

   task automatic check_outputs();
      chk("m0 vld",  96'(vld0),  96'(m_vld[0]));
      chk("m0 dat",  dat0,       m_dat[0]);
      chk("m0 err",  96'(err0),  96'(m_err[0]));
      chk("m0 busy", 96'(busy0), 96'(m_k[0] < dep(0)));
      chk("m1 vld",  96'(vld1),  96'(m_vld[1]));
      chk("m1 dat",  dat1,       m_dat[1]);
      chk("m1 err",  96'(err1),  96'(m_err[1]));
      chk("m1 busy", 96'(busy1), 96'(m_k[1] < dep(1)));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_in(input logic rv, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic wv, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd);
      rd_req_valid = rv;
      rd_req_addr  = {a2, a1, a0};
      wr_req_valid = wv;
      wr_req_addr  = wa;
      wr_req_data  = wd;
   endtask

   task automatic idle();
      set_in(1'b0, '0, '0, '0, 1'b0, '0, '0);
   endtask

   // Called on a falling edge with inputs set; returns on the next falling edge.
   task automatic step();
      if (rst_n) begin
         model_edge(0);
         model_edge(1);
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      idle();
      #1;
      chk("rst vld0",  96'(vld0),  96'd0);
      chk("rst dat0",  dat0,       96'd0);
      chk("rst busy0", 96'(busy0), 96'd1);
      chk("rst err0",  96'(err0),  96'd0);
      chk("rst vld1",  96'(vld1),  96'd0);
      chk("rst busy1", 96'(busy1), 96'd1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   // e_* are the outputs sampled after this row's edge: response fields belong to the
   // previous row's request, error fields to this row's inputs.
   typedef struct {
      logic          rv;
      logic [AW-1:0] a0, a1, a2;
      logic          wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          e_vld;
      logic [95:0]   e_dat0, e_dat1;
      logic          e_err0, e_err1;
   } vec_t;

   vec_t tbl [18];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] vD, vC, vA, vF, vE, vZ, vB9;
      int f0, f1, nv, nb;
      vD = 32'hDEADBEEF; vC = 32'h12345678; vA = 32'hA5A5A5A5;
      vF = 32'h0BADF00D; vE = 32'h11111111; vZ = 32'h0;
      vB9 = BYP ? vA : vZ;

      tbl[0]  = '{1'b1, 7'd0,   7'd64,  7'd127, 1'b0, 7'd0,   vZ, 1'b0, 96'd0,           96'd0,           1'b0, 1'b1};
      tbl[1]  = '{1'b0, 7'd0,   7'd0,   7'd0,   1'b0, 7'd0,   vZ, 1'b1, 96'd0,           96'd0,           1'b0, 1'b0};
      tbl[2]  = '{1'b0, 7'd0,   7'd0,   7'd0,   1'b1, 7'd5,   vD, 1'b0, 96'd0,           96'd0,           1'b0, 1'b0};
      tbl[3]  = '{1'b0, 7'd0,   7'd0,   7'd0,   1'b1, 7'd6,   vC, 1'b0, 96'd0,           96'd0,           1'b0, 1'b0};
      tbl[4]  = '{1'b1, 7'd5,   7'd6,   7'd5,   1'b0, 7'd0,   vZ, 1'b0, 96'd0,           96'd0,           1'b0, 1'b0};
      tbl[5]  = '{1'b1, 7'd5,   7'd6,   7'd5,   1'b0, 7'd0,   vZ, 1'b1, {vD, vC, vD},    {vD, vC, vD},    1'b0, 1'b0};
      tbl[6]  = '{1'b1, 7'd6,   7'd5,   7'd6,   1'b0, 7'd0,   vZ, 1'b1, {vD, vC, vD},    {vD, vC, vD},    1'b0, 1'b0};
      tbl[7]  = '{1'b1, 7'd0,   7'd5,   7'd6,   1'b0, 7'd0,   vZ, 1'b1, {vC, vD, vC},    {vC, vD, vC},    1'b0, 1'b0};
      tbl[8]  = '{1'b0, 7'd0,   7'd0,   7'd0,   1'b0, 7'd0,   vZ, 1'b1, {vC, vD, vZ},    {vC, vD, vZ},    1'b0, 1'b0};
      tbl[9]  = '{1'b1, 7'd9,   7'd0,   7'd0,   1'b1, 7'd9,   vA, 1'b0, {vC, vD, vZ},    {vC, vD, vZ},    1'b0, 1'b0};
      tbl[10] = '{1'b1, 7'd9,   7'd0,   7'd0,   1'b0, 7'd0,   vZ, 1'b1, {vZ, vZ, vB9},   {vZ, vZ, vB9},   1'b0, 1'b0};
      tbl[11] = '{1'b0, 7'd0,   7'd0,   7'd0,   1'b0, 7'd0,   vZ, 1'b1, {vZ, vZ, vA},    {vZ, vZ, vA},    1'b0, 1'b0};
      tbl[12] = '{1'b0, 7'd0,   7'd0,   7'd0,   1'b1, 7'd105, vF, 1'b0, {vZ, vZ, vA},    {vZ, vZ, vA},    1'b0, 1'b0};
      tbl[13] = '{1'b1, 7'd105, 7'd106, 7'd127, 1'b0, 7'd0,   vZ, 1'b0, {vZ, vZ, vA},    {vZ, vZ, vA},    1'b0, 1'b1};
      tbl[14] = '{1'b0, 7'd0,   7'd0,   7'd0,   1'b0, 7'd0,   vZ, 1'b1, {vZ, vZ, vF},    {vZ, vZ, vF},    1'b0, 1'b0};
      tbl[15] = '{1'b0, 7'd0,   7'd0,   7'd0,   1'b1, 7'd110, vE, 1'b0, {vZ, vZ, vF},    {vZ, vZ, vF},    1'b0, 1'b1};
      tbl[16] = '{1'b1, 7'd110, 7'd0,   7'd0,   1'b0, 7'd0,   vZ, 1'b0, {vZ, vZ, vF},    {vZ, vZ, vF},    1'b0, 1'b1};
      tbl[17] = '{1'b0, 7'd0,   7'd0,   7'd0,   1'b0, 7'd0,   vZ, 1'b1, {vZ, vZ, vE},    {vZ, vZ, vZ},    1'b0, 1'b0};

      @(negedge clk);
      do_reset();

      // Init length: busy must fall after exactly DEPTH edges.
      f0 = 0; f1 = 0;
      for (int i = 1; i <= 140; i++) begin
         step();
         if (!busy0 && f0 == 0) f0 = i;
         if (!busy1 && f1 == 0) f1 = i;
      end
      chk("init len 128", 96'(f0), 96'd128);
      chk("init len 106", 96'(f1), 96'd106);

      for (int i = 0; i < 18; i++) begin
         set_in(tbl[i].rv, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].wv, tbl[i].wa, tbl[i].wd);
         step();
         chk($sformatf("tbl%0d vld0", i), 96'(vld0), 96'(tbl[i].e_vld));
         chk($sformatf("tbl%0d vld1", i), 96'(vld1), 96'(tbl[i].e_vld));
         chk($sformatf("tbl%0d dat0", i), dat0, tbl[i].e_dat0);
         chk($sformatf("tbl%0d dat1", i), dat1, tbl[i].e_dat1);
         chk($sformatf("tbl%0d err0", i), 96'(err0), 96'(tbl[i].e_err0));
         chk($sformatf("tbl%0d err1", i), 96'(err1), 96'(tbl[i].e_err1));
      end
      idle();
      step();

      // Read then write issued during init: both dropped, one error pulse each.
      do_reset();
      for (int i = 0; i < 10; i++) step();
      set_in(1'b1, 7'd9, 7'd9, 7'd9, 1'b0, 7'd0, 32'h0);
      step();
      chk("init rd err0", 96'(err0), 96'd1);
      chk("init rd err1", 96'(err1), 96'd1);
      set_in(1'b0, 7'd0, 7'd0, 7'd0, 1'b1, 7'd9, 32'hCAFEF00D);
      step();
      chk("init wr err0", 96'(err0), 96'd1);
      idle();
      step();
      chk("init err gap", 96'(err0), 96'd0);
      nv = 0;
      for (int i = 0; i < 130; i++) begin
         step();
         if (vld0 || vld1) nv++;
      end
      chk("init no resp", 96'(nv), 96'd0);
      set_in(1'b1, 7'd9, 7'd9, 7'd9, 1'b0, 7'd0, 32'h0);
      step();
      idle();
      step();
      chk("init drop vld", 96'(vld0), 96'd1);
      chk("init drop dat", dat0, 96'd0);

      // Reset one cycle after an accept: the response must never appear.
      set_in(1'b1, 7'd5, 7'd5, 7'd5, 1'b0, 7'd0, 32'h0);
      step();
      do_reset();
      nv = 0; nb = 0;
      for (int i = 0; i < 135; i++) begin
         if (busy0) nb++;
         if (vld0 || vld1) nv++;
         step();
      end
      chk("rst lost resp", 96'(nv), 96'd0);
      chk("rst reinit len", 96'(nb), 96'd128);

      // Random traffic against the model; addresses cluster to provoke collisions.
      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] ra [3];
         logic [AW-1:0] wa;
         for (int p = 0; p < 3; p++)
            ra[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 127)) : AW'($urandom_range(0, 7));
         wa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 127)) : AW'($urandom_range(0, 7));
         set_in(1'($urandom_range(0, 1)), ra[0], ra[1], ra[2],
                1'($urandom_range(0, 1)), wa, $urandom);
         step();
      end
      idle();
      for (int i = 0; i < 4; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sgpr_ram.md
Name: sgpr_ram

Overview:
- Banked scalar register storage directly downstream of the SGPR read controller.
- Consumes the controller's already-rebased read request (valid-only, no backpressure) and returns RD_PORT_CNT operands after a fixed latency on a valid-only response channel.
- Also owns the SGPR write port and a post-reset zero-initialisation sequencer, so the read path never returns uninitialised data.

Parameters:
- RD_PORT_CNT, 3, number of parallel read operands per request (matches sgpr_pkg).
- DEPTH, 128, number of 32-bit SGPR entries; need not be a power of two.
- DATA_W, 32, SGPR width in bits.
- RD_LAT, 2, cycles from request accept edge to response valid; legal range 1..4.
- ADDR_W, $clog2(DEPTH), localparam; address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req_valid  in  1  read request valid (sgpr_ram_rd_req.valid); no ready.
- rd_req_addr  in  RD_PORT_CNT*ADDR_W  absolute addresses, port i at [i*ADDR_W +: ADDR_W].
- rd_resp_valid  out  1  read response valid (sgpr_ram_rd_resp.valid).
- rd_resp_data  out  RD_PORT_CNT*DATA_W  operands, port i at [i*DATA_W +: DATA_W].
- wr_req_valid  in  1  write strobe.
- wr_req_addr  in  ADDR_W  write address.
- wr_req_data  in  DATA_W  write data.
- init_busy  out  1  high while the zero-init sequence runs.
- req_err  out  1  one-cycle pulse: request dropped (during init) or address >= DEPTH.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values: rd_resp_valid=0, rd_resp_data=0, init_busy=1, req_err=0, FSM=INIT, init counter=0, valid pipeline cleared. Array contents are not touched by rst_n.
- FSM INIT:
  - Each cycle after rst_n deasserts, write 0 to array[cnt] and increment cnt.
  - When cnt==DEPTH-1 is written, go to READY; init_busy falls on the following cycle.
  - Init takes exactly DEPTH cycles.
- FSM READY: terminal state; left only via rst_n.
- Reset asserted mid-init or mid-read:
  - Pipeline valids clear immediately and the FSM returns to INIT with cnt=0.
  - In-flight responses are lost; no response ever emerges for them.
- Read timing:
  - Request sampled on edge E when rd_req_valid=1 and FSM=READY.
  - Array is read at E; data passes through RD_LAT-1 further register stages.
  - rd_resp_valid=1 for exactly one cycle, RD_LAT cycles after E; back-to-back requests give back-to-back responses (full throughput, no bubbles).
- rd_resp_data holds its last value when rd_resp_valid=0.
- Read during INIT: dropped, no response, req_err pulses the cycle after.
- Write:
  - Committed at edge when wr_req_valid=1 and FSM=READY; visible to reads sampled at later edges.
  - Write during INIT: dropped, req_err pulses.
- Out-of-range address (>=DEPTH):
  - Read: that port returns 0, other ports are unaffected, response still issued, req_err pulses.
  - Write: dropped, req_err pulses.
- Duplicate addresses across read ports in one request: each port returns the same value.
- Same-cycle read and write to the same address: governed by the optional feature.
- req_err: OR of all error sources, registered, one pulse per offending cycle.

Optional Feature:
- Macro: SGPR_RAM_WR_BYPASS_EN.
- Defined: a read port whose address equals wr_req_addr in a cycle with a committed write returns wr_req_data (write-before-read forwarding).
- Undefined: that port returns the pre-write array value (read-before-write); the new value is seen from the next request onward.

Test Plan:
- Reset, then hold rd_req_valid=0 -> init_busy=1 for exactly 128 cycles, then 0; afterwards read addrs {0,64,127} -> data {0,0,0} with rd_resp_valid 2 cycles after accept.
- Write 0xDEADBEEF@5 and 0x12345678@6, then read {5,6,5} -> {0xDEADBEEF,0x12345678,0xDEADBEEF} at accept+2; 4 back-to-back reads -> 4 consecutive valid cycles.
- In the same cycle, write 0xA5A5A5A5@9 and read {9,0,0} -> port0=0xA5A5A5A5 with SGPR_RAM_WR_BYPASS_EN, old value 0 without; a following read returns 0xA5A5A5A5 in both builds.
- With DEPTH=106, read {105,106,127} -> {stored,0,0}, response issued, req_err=1 for one cycle; write @110 -> dropped, req_err pulse.
- Read and write issued at init cycle 10 -> no response, req_err pulses twice, array entry unchanged (reads 0 after init).
- Assert rst_n low 1 cycle after a read accept -> no rd_resp_valid; init restarts, init_busy high 128 cycles.
